// File: rtl/uart_pkg.sv
// Shared definitions for the UART stream buffer.
//   FifoDepthDefault : default number of entries per FIFO
//   level_width()    : width of a FIFO occupancy value (count ranges 0..depth)
//   status_bit_e     : bit positions of the sticky status flags when packed
//                      into a register-map word
package uart_pkg;

  localparam int unsigned FifoDepthDefault = 16;

  // One extra bit so that a completely full FIFO (count == depth) is representable.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    StatTxOverflow  = 2'd0,
    StatRxOverflow  = 2'd1,
    StatRxFrameErr  = 2'd2,
    StatRxParityErr = 2'd3
  } status_bit_e;

  localparam int unsigned NumStatus = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk_i, reset_i   : clock, asynchronous active-high reset (pointers/count/flags only)
//   push_i, wdata_i  : write request and data; accepted only when not full
//   pop_i            : read request; accepted only when not empty
//   rdata_o          : current head, forced to zero while empty
//   full_o, empty_o  : registered status flags
//   level_o          : registered occupancy, 0..Depth
// Depth must be a power of two and at least 2 so the pointers wrap naturally.
module uart_sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic            pop_i,
  output logic [Width-1:0] rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] level_o
);

  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CntW-1:0]  w_count_d;

  // Acceptance looks only at the state at the start of the cycle, so a pop
  // never makes room for a same-cycle push and vice versa.
  assign w_push_ok = push_i & ~r_full;
  assign w_pop_ok  = pop_i & ~r_empty;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_d = r_count + CntW'(1);
      2'b01:   w_count_d = r_count - CntW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= w_count_d;
      r_full  <= (w_count_d == DepthCnt);
      r_empty <= (w_count_d == '0);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata_i;
  end

  // Masking while empty hides stale (or never-written) RAM contents.
  assign rdata_o = r_empty ? '0 : r_mem[r_rd_ptr];
  assign full_o  = r_full;
  assign empty_o = r_empty;
  assign level_o = r_count;

endmodule

// File: rtl/uart_stream_buffer.sv
// Byte-stream buffer between a host client and the UART core.
//   TX: host writes (tx_data_i/tx_wr_i) fill a FIFO that drains through the
//       uart_data_o / uart_data_valid_o / uart_data_in_ready_i handshake.
//   RX: bytes from the receiver (uart_data_i/uart_data_valid_i plus error
//       qualifiers) fill a FIFO the host pops with rx_rd_i; rx_data_o is the
//       FWFT head.
//   Status: sticky tx_overflow_o, rx_overflow_o, rx_frame_err_o,
//       rx_parity_err_o; cleared by clear_status_i, a same-cycle set wins.
// Reset (reset_i) is asynchronous and active-high.
module uart_stream_buffer
  import uart_pkg::*;
#(
  parameter int unsigned FifoDepth   = FifoDepthDefault,
  parameter int unsigned DropOnError = 1,
  localparam int unsigned LevelWidth = level_width(FifoDepth)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  // Host TX side
  input  logic [7:0]            tx_data_i,
  input  logic                  tx_wr_i,
  output logic                  tx_full_o,
  output logic [LevelWidth-1:0] tx_level_o,
  // UART transmitter handshake
  output logic [7:0]            uart_data_o,
  output logic                  uart_data_valid_o,
  input  logic                  uart_data_in_ready_i,
  // UART receiver
  input  logic [7:0]            uart_data_i,
  input  logic                  uart_data_valid_i,
  input  logic                  uart_frame_error_i,
  input  logic                  uart_parity_error_i,
  // Host RX side
  output logic [7:0]            rx_data_o,
  input  logic                  rx_rd_i,
  output logic                  rx_empty_o,
  output logic [LevelWidth-1:0] rx_level_o,
  // Status
  input  logic                  clear_status_i,
  output logic                  tx_overflow_o,
  output logic                  rx_overflow_o,
  output logic                  rx_frame_err_o,
  output logic                  rx_parity_err_o
);

  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic                  w_tx_pop;
  logic                  w_rx_full;
  logic                  w_rx_err;
  logic                  w_rx_push;
  logic                  w_drop_en;
  logic [NumStatus-1:0]  w_status_set;
  logic [NumStatus-1:0]  r_status;

  // ---------------------------------------------------------------- TX path
  assign w_tx_pop = ~w_tx_empty & uart_data_in_ready_i;

  uart_sync_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (tx_wr_i),
    .wdata_i (tx_data_i),
    .pop_i   (w_tx_pop),
    .rdata_o (uart_data_o),
    .full_o  (w_tx_full),
    .empty_o (w_tx_empty),
    .level_o (tx_level_o)
  );

  assign tx_full_o         = w_tx_full;
  assign uart_data_valid_o = ~w_tx_empty;

  // ---------------------------------------------------------------- RX path
  assign w_drop_en = (DropOnError != 0);
  assign w_rx_err  = uart_frame_error_i | uart_parity_error_i;
  assign w_rx_push = uart_data_valid_i & ~(w_drop_en & w_rx_err);

  uart_sync_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_rx_push),
    .wdata_i (uart_data_i),
    .pop_i   (rx_rd_i),
    .rdata_o (rx_data_o),
    .full_o  (w_rx_full),
    .empty_o (rx_empty_o),
    .level_o (rx_level_o)
  );

  // ---------------------------------------------------------- Sticky status
  always_comb begin
    w_status_set                  = '0;
    w_status_set[StatTxOverflow]  = tx_wr_i & w_tx_full;
    // Only a byte that would actually have been stored counts as an overflow.
    w_status_set[StatRxOverflow]  = w_rx_push & w_rx_full;
    w_status_set[StatRxFrameErr]  = uart_data_valid_i & uart_frame_error_i;
    w_status_set[StatRxParityErr] = uart_data_valid_i & uart_parity_error_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_status <= '0;
    end else begin
      r_status <= w_status_set | (r_status & ~{NumStatus{clear_status_i}});
    end
  end

  assign tx_overflow_o   = r_status[StatTxOverflow];
  assign rx_overflow_o   = r_status[StatRxOverflow];
  assign rx_frame_err_o  = r_status[StatRxFrameErr];
  assign rx_parity_err_o = r_status[StatRxParityErr];

endmodule

// File: tb/tb_uart_stream_buffer.sv
module tb_uart_stream_buffer;

  localparam int unsigned Depth = 16;
  localparam int unsigned LW    = 5;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [7:0]    tx_data_i;
  logic          tx_wr_i;
  logic          uart_data_in_ready_i;
  logic [7:0]    uart_data_i;
  logic          uart_data_valid_i;
  logic          uart_frame_error_i;
  logic          uart_parity_error_i;
  logic          rx_rd_i;
  logic          clear_status_i;

  // Outputs of the DropOnError = 1 instance
  logic          tx_full_o, uart_data_valid_o, rx_empty_o;
  logic [LW-1:0] tx_level_o, rx_level_o;
  logic [7:0]    uart_data_o, rx_data_o;
  logic          tx_overflow_o, rx_overflow_o, rx_frame_err_o, rx_parity_err_o;

  // Outputs of the DropOnError = 0 instance (shares all inputs)
  logic          b_tx_full, b_tx_valid, b_rx_empty;
  logic [LW-1:0] b_tx_level, b_rx_level;
  logic [7:0]    b_tx_data, b_rx_data;
  logic          b_tx_ovf, b_rx_ovf, b_frame, b_parity;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_b;

  always #5 clk_i = ~clk_i;

  uart_stream_buffer #(.FifoDepth(Depth), .DropOnError(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .tx_data_i(tx_data_i), .tx_wr_i(tx_wr_i), .tx_full_o(tx_full_o), .tx_level_o(tx_level_o),
    .uart_data_o(uart_data_o), .uart_data_valid_o(uart_data_valid_o),
    .uart_data_in_ready_i(uart_data_in_ready_i),
    .uart_data_i(uart_data_i), .uart_data_valid_i(uart_data_valid_i),
    .uart_frame_error_i(uart_frame_error_i), .uart_parity_error_i(uart_parity_error_i),
    .rx_data_o(rx_data_o), .rx_rd_i(rx_rd_i), .rx_empty_o(rx_empty_o), .rx_level_o(rx_level_o),
    .clear_status_i(clear_status_i), .tx_overflow_o(tx_overflow_o),
    .rx_overflow_o(rx_overflow_o), .rx_frame_err_o(rx_frame_err_o),
    .rx_parity_err_o(rx_parity_err_o)
  );

  uart_stream_buffer #(.FifoDepth(Depth), .DropOnError(0)) dut_keep (
    .clk_i(clk_i), .reset_i(reset_i),
    .tx_data_i(tx_data_i), .tx_wr_i(tx_wr_i), .tx_full_o(b_tx_full), .tx_level_o(b_tx_level),
    .uart_data_o(b_tx_data), .uart_data_valid_o(b_tx_valid),
    .uart_data_in_ready_i(uart_data_in_ready_i),
    .uart_data_i(uart_data_i), .uart_data_valid_i(uart_data_valid_i),
    .uart_frame_error_i(uart_frame_error_i), .uart_parity_error_i(uart_parity_error_i),
    .rx_data_o(b_rx_data), .rx_rd_i(rx_rd_i), .rx_empty_o(b_rx_empty), .rx_level_o(b_rx_level),
    .clear_status_i(clear_status_i), .tx_overflow_o(b_tx_ovf),
    .rx_overflow_o(b_rx_ovf), .rx_frame_err_o(b_frame), .rx_parity_err_o(b_parity)
  );

  // Advance one clock; outputs are then sampled and inputs changed 1 ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    tx_wr_i = 1'b0; uart_data_in_ready_i = 1'b0; uart_data_valid_i = 1'b0;
    uart_frame_error_i = 1'b0; uart_parity_error_i = 1'b0; rx_rd_i = 1'b0;
    clear_status_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    tx_data_i = 8'h00; uart_data_i = 8'h00;
    reset_i = 1'b1;
    step(); step();
    reset_i = 1'b0;
    step();
    n_vec++; if (tx_level_o !== 5'd0) begin n_err++; $display("FAIL reset_tx_level got %0d want 0", tx_level_o); end
    n_vec++; if (rx_level_o !== 5'd0) begin n_err++; $display("FAIL reset_rx_level got %0d want 0", rx_level_o); end
    n_vec++; if ({tx_full_o, rx_empty_o, uart_data_valid_o} !== 3'b010) begin
      n_err++; $display("FAIL reset_flags full/empty/valid got %b want 010", {tx_full_o, rx_empty_o, uart_data_valid_o}); end
    n_vec++; if ({uart_data_o, rx_data_o} !== 16'h0000) begin
      n_err++; $display("FAIL reset_data got %h/%h want 00/00", uart_data_o, rx_data_o); end
    n_vec++; if ({tx_overflow_o, rx_overflow_o, rx_frame_err_o, rx_parity_err_o} !== 4'b0000) begin
      n_err++; $display("FAIL reset_sticky got %b want 0000",
                        {tx_overflow_o, rx_overflow_o, rx_frame_err_o, rx_parity_err_o}); end
  endtask

  task automatic test_tx_order();
    logic [7:0] bytes [3] = '{8'hA5, 8'h5A, 8'h3C};
    uart_data_in_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_data_i = bytes[i]; tx_wr_i = 1'b1; tx_q.push_back(bytes[i]);
      step();
      if (i == 0) begin
        n_vec++; if (uart_data_valid_o !== 1'b1) begin n_err++; $display("FAIL tx_valid_latency got %b want 1", uart_data_valid_o); end
      end
    end
    tx_wr_i = 1'b0;
    step(); step();
    n_vec++; if (tx_level_o !== 5'd3) begin n_err++; $display("FAIL tx_level3 got %0d want 3", tx_level_o); end
    n_vec++; if (uart_data_o !== 8'hA5) begin n_err++; $display("FAIL tx_head_steady got %h want a5", uart_data_o); end
    uart_data_in_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_b = tx_q.pop_front();
      n_vec++; if (uart_data_valid_o !== 1'b1 || uart_data_o !== exp_b) begin
        n_err++; $display("FAIL tx_emit[%0d] got %h valid %b want %h", i, uart_data_o, uart_data_valid_o, exp_b); end
      step();
    end
    uart_data_in_ready_i = 1'b0;
    n_vec++; if (uart_data_valid_o !== 1'b0 || tx_level_o !== 5'd0) begin
      n_err++; $display("FAIL tx_drained valid %b level %0d want 0/0", uart_data_valid_o, tx_level_o); end
  endtask

  task automatic test_tx_overflow();
    uart_data_in_ready_i = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      tx_data_i = 8'(i * 7 + 1); tx_wr_i = 1'b1; tx_q.push_back(8'(i * 7 + 1));
      step();
    end
    tx_wr_i = 1'b0;
    n_vec++; if (tx_full_o !== 1'b1 || tx_level_o !== 5'd16 || tx_overflow_o !== 1'b0) begin
      n_err++; $display("FAIL tx_fill full %b level %0d ovf %b want 1/16/0", tx_full_o, tx_level_o, tx_overflow_o); end
    tx_data_i = 8'hFF; tx_wr_i = 1'b1;
    step();
    tx_wr_i = 1'b0;
    n_vec++; if (tx_full_o !== 1'b1 || tx_level_o !== 5'd16 || tx_overflow_o !== 1'b1) begin
      n_err++; $display("FAIL tx_overflow full %b level %0d ovf %b want 1/16/1", tx_full_o, tx_level_o, tx_overflow_o); end
    clear_status_i = 1'b1;
    step();
    clear_status_i = 1'b0;
    n_vec++; if (tx_overflow_o !== 1'b0) begin n_err++; $display("FAIL tx_ovf_clear got %b want 0", tx_overflow_o); end
    // Set and clear together: the set wins.
    tx_wr_i = 1'b1; clear_status_i = 1'b1;
    step();
    tx_wr_i = 1'b0; clear_status_i = 1'b0;
    n_vec++; if (tx_overflow_o !== 1'b1) begin n_err++; $display("FAIL tx_set_wins got %b want 1", tx_overflow_o); end
    clear_status_i = 1'b1; step(); clear_status_i = 1'b0;
    uart_data_in_ready_i = 1'b1;
    for (int c = 0; c < 40 && tx_q.size() > 0; c++) begin
      if (uart_data_valid_o === 1'b1) begin
        exp_b = tx_q.pop_front();
        n_vec++; if (uart_data_o !== exp_b) begin
          n_err++; $display("FAIL tx_drain_data got %h want %h", uart_data_o, exp_b); end
      end
      step();
    end
    uart_data_in_ready_i = 1'b0;
    n_vec++; if (tx_q.size() != 0 || uart_data_valid_o !== 1'b0) begin
      n_err++; $display("FAIL tx_drain_done left %0d valid %b want 0/0", tx_q.size(), uart_data_valid_o);
      tx_q.delete(); end
  endtask

  task automatic test_rx_basic();
    uart_data_valid_i = 1'b1;
    uart_data_i = 8'h11; rx_q.push_back(8'h11);
    step();
    n_vec++; if (rx_empty_o !== 1'b0) begin n_err++; $display("FAIL rx_empty_latency got %b want 0", rx_empty_o); end
    uart_data_i = 8'h22; rx_q.push_back(8'h22);
    step();
    uart_data_valid_i = 1'b0;
    rx_rd_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_b = rx_q.pop_front();
      n_vec++; if (rx_data_o !== exp_b) begin n_err++; $display("FAIL rx_head[%0d] got %h want %h", i, rx_data_o, exp_b); end
      step();
    end
    rx_rd_i = 1'b0;
    n_vec++; if (rx_empty_o !== 1'b1 || rx_data_o !== 8'h00) begin
      n_err++; $display("FAIL rx_empty_after empty %b data %h want 1/00", rx_empty_o, rx_data_o); end
  endtask

  task automatic test_rx_error();
    uart_data_valid_i = 1'b1; uart_data_i = 8'h33; uart_parity_error_i = 1'b1;
    step();
    uart_data_valid_i = 1'b0; uart_parity_error_i = 1'b0;
    n_vec++; if (rx_level_o !== 5'd0 || rx_parity_err_o !== 1'b1 || rx_frame_err_o !== 1'b0) begin
      n_err++; $display("FAIL rx_drop_parity level %0d par %b frm %b want 0/1/0", rx_level_o, rx_parity_err_o, rx_frame_err_o); end
    n_vec++; if (b_rx_level !== 5'd1 || b_rx_data !== 8'h33 || b_parity !== 1'b1) begin
      n_err++; $display("FAIL rx_keep_parity level %0d head %h par %b want 1/33/1", b_rx_level, b_rx_data, b_parity); end
    uart_data_valid_i = 1'b1; uart_data_i = 8'h44; uart_frame_error_i = 1'b1;
    step();
    uart_data_valid_i = 1'b0; uart_frame_error_i = 1'b0;
    n_vec++; if (rx_level_o !== 5'd0 || rx_frame_err_o !== 1'b1 || b_rx_level !== 5'd2 || b_frame !== 1'b1) begin
      n_err++; $display("FAIL rx_frame level %0d/%0d frm %b/%b want 0/2 1/1", rx_level_o, b_rx_level, rx_frame_err_o, b_frame); end
    // Error qualifiers without a valid strobe must not set anything.
    uart_frame_error_i = 1'b1; uart_parity_error_i = 1'b1; clear_status_i = 1'b1;
    rx_rd_i = 1'b1;
    step(); step();
    uart_frame_error_i = 1'b0; uart_parity_error_i = 1'b0; clear_status_i = 1'b0; rx_rd_i = 1'b0;
    n_vec++; if ({rx_frame_err_o, rx_parity_err_o, b_rx_level, rx_level_o} !== {2'b00, 5'd0, 5'd0}) begin
      n_err++; $display("FAIL rx_err_clear frm %b par %b levels %0d/%0d want 0 0 0/0",
                        rx_frame_err_o, rx_parity_err_o, b_rx_level, rx_level_o); end
  endtask

  task automatic test_rx_full();
    uart_data_valid_i = 1'b1;
    for (int i = 0; i < Depth; i++) begin
      uart_data_i = 8'(8'h80 + i * 3); rx_q.push_back(8'(8'h80 + i * 3));
      step();
    end
    n_vec++; if (rx_level_o !== 5'd16 || rx_overflow_o !== 1'b0) begin
      n_err++; $display("FAIL rx_fill level %0d ovf %b want 16/0", rx_level_o, rx_overflow_o); end
    uart_data_i = 8'hEE; rx_rd_i = 1'b1;
    exp_b = rx_q.pop_front();
    n_vec++; if (rx_data_o !== exp_b) begin n_err++; $display("FAIL rx_full_head got %h want %h", rx_data_o, exp_b); end
    step();
    uart_data_valid_i = 1'b0;
    n_vec++; if (rx_level_o !== 5'd15 || rx_overflow_o !== 1'b1) begin
      n_err++; $display("FAIL rx_full_pushpop level %0d ovf %b want 15/1", rx_level_o, rx_overflow_o); end
    for (int c = 0; c < 40 && rx_q.size() > 0; c++) begin
      exp_b = rx_q.pop_front();
      n_vec++; if (rx_data_o !== exp_b) begin n_err++; $display("FAIL rx_drain_data got %h want %h", rx_data_o, exp_b); end
      step();
    end
    n_vec++; if (rx_empty_o !== 1'b1) begin n_err++; $display("FAIL rx_drain_empty got %b want 1", rx_empty_o); end
    // Push and pop into an empty FIFO: the pop is ignored.
    uart_data_valid_i = 1'b1; uart_data_i = 8'h77;
    step();
    uart_data_valid_i = 1'b0; rx_rd_i = 1'b0;
    n_vec++; if (rx_level_o !== 5'd1 || rx_data_o !== 8'h77) begin
      n_err++; $display("FAIL rx_empty_pushpop level %0d head %h want 1/77", rx_level_o, rx_data_o); end
    rx_rd_i = 1'b1; clear_status_i = 1'b1;
    step(); step();
    rx_rd_i = 1'b0; clear_status_i = 1'b0;
  endtask

  task automatic test_async_reset();
    uart_data_in_ready_i = 1'b0;
    tx_wr_i = 1'b1; uart_data_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_data_i = 8'(8'h40 + i); uart_data_i = 8'(8'h90 + i);
      step();
    end
    n_vec++; if (tx_level_o !== 5'd8 || rx_level_o !== 5'd8) begin
      n_err++; $display("FAIL pre_reset_levels got %0d/%0d want 8/8", tx_level_o, rx_level_o); end
    #2;
    reset_i = 1'b1;
    #1;
    n_vec++; if ({tx_level_o, rx_level_o, tx_full_o, rx_empty_o, uart_data_valid_o, uart_data_o, rx_data_o}
                 !== {5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00}) begin
      n_err++; $display("FAIL async_reset levels %0d/%0d empty %b valid %b data %h/%h want 0/0 1 0 00/00",
                        tx_level_o, rx_level_o, rx_empty_o, uart_data_valid_o, uart_data_o, rx_data_o); end
    idle_inputs();
    step();
    #2;
    reset_i = 1'b0;
    tx_data_i = 8'h5C; tx_wr_i = 1'b1; uart_data_i = 8'h6D; uart_data_valid_i = 1'b1;
    step();
    idle_inputs();
    n_vec++; if (tx_level_o !== 5'd1 || uart_data_o !== 8'h5C || uart_data_valid_o !== 1'b1) begin
      n_err++; $display("FAIL post_reset_tx level %0d head %h valid %b want 1/5c/1", tx_level_o, uart_data_o, uart_data_valid_o); end
    n_vec++; if (rx_level_o !== 5'd1 || rx_data_o !== 8'h6D) begin
      n_err++; $display("FAIL post_reset_rx level %0d head %h want 1/6d", rx_level_o, rx_data_o); end
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_rx_basic();
    test_rx_error();
    test_rx_full();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
